// File: rtl/data_io_fifo.sv
// data_io_fifo: SPI file-download receiver feeding a small write FIFO
// and a paced memory write port with size and overflow reporting.
module data_io_fifo #(
    parameter int              DW       = 16,
    parameter int              AW       = 25,
    parameter int              FIFO_AW  = 2,
    parameter logic [AW-1:0]   BASE0    = 25'h0E0000,
    parameter logic [AW-1:0]   BASE1    = 25'h100000,
    parameter logic [AW-1:0]   BASE_DEF = 25'h120000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    input  logic          ioctl_wait,
    output logic          ioctl_download,
    output logic [4:0]    ioctl_index,
    output logic          ioctl_we,
    output logic [AW-1:0] ioctl_addr,
    output logic [DW-1:0] ioctl_dout,
    output logic [AW-1:0] ioctl_size,
    output logic          ioctl_ovf
);

    localparam int            DEPTH = 1 << FIFO_AW;
    localparam int            EW    = AW + DW;
    localparam logic [7:0]    C_IDX = 8'h55;
    localparam logic [7:0]    C_TX  = 8'h53;
    localparam logic [7:0]    C_DAT = 8'h54;
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_WRITE = 2'd1;
    localparam logic [1:0]    S_GAP   = 2'd2;
    localparam logic [AW-1:0] STEP  = AW'(DW / 8);

    logic [2:0]         sck_q;
    logic [1:0]         ss_q;
    logic [1:0]         di_q;
    logic               ss;
    logic               sck_rise;
    logic [2:0]         bit_cnt;
    logic [6:0]         sr;
    logic               got_cmd;
    logic               rx_stb;
    logic               rx_is_cmd;
    logic [7:0]         rx_byte;
    logic [7:0]         cmd;
    logic [AW-1:0]      addr;
    logic [7:0]         pend;
    logic               pend_valid;
    logic               draining;
    logic [1:0]         state;
    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW:0]   wptr;
    logic [FIFO_AW:0]   rptr;
    logic               empty;
    logic               full;
    logic               is_cmd;
    logic               is_pay;
    logic               start;
    logic               stop;
    logic               data_b;
    logic               pop;
    logic               push;
    logic               do_push;
    logic               ovf_set;
    logic [DW-1:0]      push_data;
    logic [AW-1:0]      base;
    logic [EW-1:0]      head;

    assign ss       = ss_q[1];
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign head     = mem[rptr[FIFO_AW-1:0]];
    assign ioctl_we = (state == S_WRITE);

    assign is_cmd  = rx_stb & rx_is_cmd;
    assign is_pay  = rx_stb & ~rx_is_cmd;
    assign start   = is_pay && (cmd == C_TX) && rx_byte[0];
    assign stop    = is_pay && (cmd == C_TX) && !rx_byte[0] && ioctl_download;
    assign data_b  = is_pay && (cmd == C_DAT);
    assign pop     = (state == S_WRITE);
    assign ovf_set = push && full && !pop;
    assign do_push = push && (!full || pop);

    assign base = (ioctl_index == 5'd0) ? BASE0 :
                  (ioctl_index == 5'd1) ? BASE1 : BASE_DEF;

    // Select what (if anything) enters the FIFO this cycle
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (data_b && ioctl_download) begin
            if (DW == 8) begin
                push      = 1'b1;
                push_data = DW'(rx_byte);
            end else begin
                push      = pend_valid;
                push_data = DW'({rx_byte, pend});
            end
        end else if (stop && DW == 16 && pend_valid) begin
            push      = 1'b1;
            push_data = DW'({8'h00, pend});
        end
    end

    // Synchronise SPI pins; SCK keeps one extra stage for edge detect
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_q <= '0;
            ss_q  <= 2'b11;
            di_q  <= '0;
        end else begin
            sck_q <= {sck_q[1:0], SPI_SCK};
            ss_q  <= {ss_q[0], SPI_SS2};
            di_q  <= {di_q[0], SPI_DI};
        end
    end

    // Shift in bits on SCK rising edges and strobe out whole bytes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            sr        <= '0;
            got_cmd   <= 1'b0;
            rx_stb    <= 1'b0;
            rx_is_cmd <= 1'b0;
            rx_byte   <= '0;
        end else begin
            rx_stb <= 1'b0;
            if (ss) begin
                bit_cnt <= '0;
                got_cmd <= 1'b0;
            end else if (sck_rise) begin
                sr      <= {sr[5:0], di_q[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_stb    <= 1'b1;
                    rx_byte   <= {sr, di_q[1]};
                    rx_is_cmd <= !got_cmd;
                    got_cmd   <= 1'b1;
                end
            end
        end
    end

    // Command decode, download state, address and byte accounting
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cmd            <= '0;
            ioctl_index    <= '0;
            ioctl_download <= 1'b0;
            ioctl_size     <= '0;
            ioctl_ovf      <= 1'b0;
            addr           <= '0;
            pend           <= '0;
            pend_valid     <= 1'b0;
            draining       <= 1'b0;
        end else begin
            if (draining && empty && state == S_IDLE && !push) begin
                ioctl_download <= 1'b0;
                draining       <= 1'b0;
            end
            if (is_cmd)
                cmd <= rx_byte;
            if (is_pay && cmd == C_IDX)
                ioctl_index <= rx_byte[4:0];
            if (data_b) begin
                if (ioctl_size != '1)
                    ioctl_size <= ioctl_size + 1'b1;
                if (DW == 16 && ioctl_download) begin
                    if (!pend_valid) begin
                        pend       <= rx_byte;
                        pend_valid <= 1'b1;
                    end else begin
                        pend_valid <= 1'b0;
                    end
                end
            end
            if (push)
                addr <= addr + STEP;
            if (ovf_set)
                ioctl_ovf <= 1'b1;
            if (stop) begin
                draining   <= 1'b1;
                pend_valid <= 1'b0;
            end
            if (start) begin
                addr           <= base;
                ioctl_size     <= '0;
                ioctl_ovf      <= 1'b0;
                pend_valid     <= 1'b0;
                ioctl_download <= 1'b1;
                draining       <= 1'b0;
            end
        end
    end

    // FIFO pointers; a start command empties the queue
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (start) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage holds {addr, data}; contents need no reset
    always_ff @(posedge clk_sys) begin
        if (do_push)
            mem[wptr[FIFO_AW-1:0]] <= {addr, push_data};
    end

    // Write port: launch from FIFO head, strobe once, then idle a cycle
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ioctl_addr <= '0;
            ioctl_dout <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!empty && !ioctl_wait && !start) begin
                        ioctl_addr <= head[EW-1:DW];
                        ioctl_dout <= head[DW-1:0];
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: state <= S_GAP;
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_io_fifo.sv
// tb_data_io_fifo: scoreboard bench driving one DW=16 and one DW=8
// instance over a shared SPI bus with per-instance select.
module tb_data_io_fifo;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sck;
    logic        ss;
    logic        di;
    logic        sel;
    logic        ss16;
    logic        ss8;
    logic        wait16;
    logic        wait8;

    logic        dl16, we16, ovf16;
    logic [4:0]  idx16;
    logic [24:0] a16, sz16;
    logic [15:0] d16;
    logic        dl8, we8, ovf8;
    logic [4:0]  idx8;
    logic [24:0] a8, sz8;
    logic [7:0]  d8;

    logic [40:0] exp16[$];
    logic [32:0] exp8[$];
    logic [7:0]  fbuf[8];

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int last16 = -10;
    int last8 = -10;
    int n16 = 0;
    int n8 = 0;

    always #5 clk_sys = ~clk_sys;

    assign ss16 = sel ? 1'b1 : ss;
    assign ss8  = sel ? ss : 1'b1;

    data_io_fifo #(.DW(16)) u16 (
        .clk_sys(clk_sys), .reset(reset),
        .SPI_SCK(sck), .SPI_SS2(ss16), .SPI_DI(di),
        .ioctl_wait(wait16), .ioctl_download(dl16),
        .ioctl_index(idx16), .ioctl_we(we16),
        .ioctl_addr(a16), .ioctl_dout(d16),
        .ioctl_size(sz16), .ioctl_ovf(ovf16)
    );

    data_io_fifo #(.DW(8)) u8 (
        .clk_sys(clk_sys), .reset(reset),
        .SPI_SCK(sck), .SPI_SS2(ss8), .SPI_DI(di),
        .ioctl_wait(wait8), .ioctl_download(dl8),
        .ioctl_index(idx8), .ioctl_we(we8),
        .ioctl_addr(a8), .ioctl_dout(d8),
        .ioctl_size(sz8), .ioctl_ovf(ovf8)
    );

    task automatic tick();
        logic [40:0] e16;
        logic [32:0] e8;
        @(posedge clk_sys);
        #1;
        cyc++;
        if (we16 === 1'b1) begin
            n16++;
            vec++;
            if (cyc - last16 < 2) begin
                miss++;
                $display("FAIL gap16 spacing=%0d required>=2", cyc - last16);
            end
            last16 = cyc;
            vec++;
            if (exp16.size() == 0) begin
                miss++;
                $display("FAIL wr16 unexpected addr=%h data=%h", a16, d16);
            end else begin
                e16 = exp16.pop_front();
                if ({a16, d16} !== e16) begin
                    miss++;
                    $display("FAIL wr16 got=%h/%h required=%h/%h",
                             a16, d16, e16[40:16], e16[15:0]);
                end
            end
        end
        if (we8 === 1'b1) begin
            n8++;
            vec++;
            if (cyc - last8 < 2) begin
                miss++;
                $display("FAIL gap8 spacing=%0d required>=2", cyc - last8);
            end
            last8 = cyc;
            vec++;
            if (exp8.size() == 0) begin
                miss++;
                $display("FAIL wr8 unexpected addr=%h data=%h", a8, d8);
            end else begin
                e8 = exp8.pop_front();
                if ({a8, d8} !== e8) begin
                    miss++;
                    $display("FAIL wr8 got=%h/%h required=%h/%h",
                             a8, d8, e8[32:8], e8[7:0]);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic spi_bit(input logic b);
        sck = 1'b0;
        di  = b;
        ticks(4);
        sck = 1'b1;
        ticks(4);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame(input int n);
        ss = 1'b0;
        ticks(4);
        for (int i = 0; i < n; i++) spi_byte(fbuf[i]);
        sck = 1'b0;
        ticks(4);
        ss = 1'b1;
        ticks(8);
    endtask

    task automatic frame2(input logic [7:0] c, input logic [7:0] p);
        fbuf[0] = c;
        fbuf[1] = p;
        frame(2);
    endtask

    task automatic wait_done(input bit w8, input string nm);
        int i;
        for (i = 0; i < 400; i++) begin
            if ((w8 ? dl8 : dl16) === 1'b0) break;
            tick();
        end
        vec++;
        if ((w8 ? dl8 : dl16) !== 1'b0) begin
            miss++;
            $display("FAIL %s download still=1 required=0 after 400 cycles", nm);
        end
    endtask

    task automatic chk_q_empty(input bit w8, input string nm);
        int left;
        left = w8 ? exp8.size() : exp16.size();
        vec++;
        if (left != 0) begin
            miss++;
            $display("FAIL %s pending writes=%0d required=0", nm, left);
        end
        exp8.delete();
        exp16.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ticks(3);
        vec++;
        if ({dl16, idx16, we16, a16, d16, sz16, ovf16} !== '0) begin
            miss++;
            $display("FAIL reset16 got=%h required=0",
                     {dl16, idx16, we16, a16, d16, sz16, ovf16});
        end
        vec++;
        if ({dl8, idx8, we8, a8, d8, sz8, ovf8} !== '0) begin
            miss++;
            $display("FAIL reset8 got=%h required=0",
                     {dl8, idx8, we8, a8, d8, sz8, ovf8});
        end
        reset = 1'b0;
        ticks(3);
    endtask

    task automatic test_index();
        sel = 1'b0;
        frame2(8'h55, 8'h01);
        vec++;
        if (idx16 !== 5'd1) begin
            miss++;
            $display("FAIL index got=%0d required=1", idx16);
        end
        frame2(8'h53, 8'h01);
        vec++;
        if (dl16 !== 1'b1) begin
            miss++;
            $display("FAIL start_dl got=%b required=1", dl16);
        end
        exp16.push_back({25'h100000, 16'h2211});
        exp16.push_back({25'h100002, 16'h4433});
        fbuf[0] = 8'h54;
        fbuf[1] = 8'h11;
        fbuf[2] = 8'h22;
        fbuf[3] = 8'h33;
        fbuf[4] = 8'h44;
        frame(5);
        frame2(8'h53, 8'h00);
        wait_done(1'b0, "index_drain");
        vec++;
        if (sz16 !== 25'd4) begin
            miss++;
            $display("FAIL index_size got=%0d required=4", sz16);
        end
        chk_q_empty(1'b0, "index_writes");
    endtask

    task automatic test_odd_length();
        sel = 1'b0;
        frame2(8'h55, 8'h00);
        frame2(8'h53, 8'h01);
        exp16.push_back({25'h0E0000, 16'hBBAA});
        exp16.push_back({25'h0E0002, 16'h00CC});
        fbuf[0] = 8'h54;
        fbuf[1] = 8'hAA;
        fbuf[2] = 8'hBB;
        fbuf[3] = 8'hCC;
        frame(4);
        frame2(8'h53, 8'h00);
        wait_done(1'b0, "odd_drain");
        vec++;
        if (sz16 !== 25'd3) begin
            miss++;
            $display("FAIL odd_size got=%0d required=3", sz16);
        end
        chk_q_empty(1'b0, "odd_writes");
    endtask

    task automatic test_back_pressure();
        int n0;
        sel   = 1'b1;
        wait8 = 1'b1;
        frame2(8'h55, 8'h00);
        frame2(8'h53, 8'h01);
        n0 = n8;
        fbuf[0] = 8'h54;
        for (int i = 1; i <= 4; i++) fbuf[i] = 8'(8'hC0 + i);
        frame(5);
        ticks(20);
        vec++;
        if (n8 !== n0) begin
            miss++;
            $display("FAIL bp_hold writes=%0d required=0", n8 - n0);
        end
        vec++;
        if (ovf8 !== 1'b0) begin
            miss++;
            $display("FAIL bp_ovf got=%b required=0", ovf8);
        end
        for (int i = 0; i < 4; i++)
            exp8.push_back({25'h0E0000 + 25'(i), 8'(8'hC1 + i)});
        wait8 = 1'b0;
        frame2(8'h53, 8'h00);
        wait_done(1'b1, "bp_drain");
        chk_q_empty(1'b1, "bp_writes");
    endtask

    task automatic test_overflow();
        sel   = 1'b1;
        wait8 = 1'b1;
        frame2(8'h53, 8'h01);
        fbuf[0] = 8'h54;
        for (int i = 1; i <= 6; i++) fbuf[i] = 8'(8'h30 + i);
        frame(7);
        vec++;
        if (ovf8 !== 1'b1) begin
            miss++;
            $display("FAIL ovf_flag got=%b required=1", ovf8);
        end
        for (int i = 0; i < 4; i++)
            exp8.push_back({25'h0E0000 + 25'(i), 8'(8'h31 + i)});
        wait8 = 1'b0;
        frame2(8'h53, 8'h00);
        wait_done(1'b1, "ovf_drain");
        chk_q_empty(1'b1, "ovf_writes");
        vec++;
        if (sz8 !== 25'd6) begin
            miss++;
            $display("FAIL ovf_size got=%0d required=6", sz8);
        end
        vec++;
        if (ovf8 !== 1'b1) begin
            miss++;
            $display("FAIL ovf_sticky got=%b required=1", ovf8);
        end
    endtask

    task automatic test_ss_abort();
        sel   = 1'b1;
        wait8 = 1'b0;
        frame2(8'h53, 8'h01);
        exp8.push_back({25'h0E0000, 8'h10});
        exp8.push_back({25'h0E0001, 8'h5A});
        ss = 1'b0;
        ticks(4);
        spi_byte(8'h54);
        spi_byte(8'h10);
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        sck = 1'b0;
        ticks(4);
        ss = 1'b1;
        ticks(8);
        vec++;
        if (sz8 !== 25'd1) begin
            miss++;
            $display("FAIL abort_size got=%0d required=1", sz8);
        end
        frame2(8'h54, 8'h5A);
        frame2(8'h53, 8'h00);
        wait_done(1'b1, "abort_drain");
        chk_q_empty(1'b1, "abort_writes");
        vec++;
        if (sz8 !== 25'd2) begin
            miss++;
            $display("FAIL abort_size2 got=%0d required=2", sz8);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        sel    = 1'b0;
        wait16 = 1'b1;
        frame2(8'h53, 8'h01);
        fbuf[0] = 8'h54;
        for (int i = 1; i <= 4; i++) fbuf[i] = 8'(i);
        frame(5);
        reset = 1'b1;
        tick();
        vec++;
        if ({dl16, idx16, we16, a16, d16, sz16, ovf16} !== '0) begin
            miss++;
            $display("FAIL rst_mid got=%h required=0",
                     {dl16, idx16, we16, a16, d16, sz16, ovf16});
        end
        reset  = 1'b0;
        wait16 = 1'b0;
        n0 = n16;
        ticks(30);
        vec++;
        if (n16 !== n0) begin
            miss++;
            $display("FAIL rst_mid_we writes=%0d required=0", n16 - n0);
        end
        frame2(8'h53, 8'h01);
        exp16.push_back({25'h0E0000, 16'hB2A1});
        fbuf[0] = 8'h54;
        fbuf[1] = 8'hA1;
        fbuf[2] = 8'hB2;
        frame(3);
        frame2(8'h53, 8'h00);
        wait_done(1'b0, "rst_restart");
        chk_q_empty(1'b0, "rst_restart_writes");
    endtask

    initial begin
        reset  = 1'b1;
        sck    = 1'b0;
        ss     = 1'b1;
        di     = 1'b0;
        sel    = 1'b0;
        wait16 = 1'b0;
        wait8  = 1'b0;
        test_reset();
        test_index();
        test_odd_length();
        test_back_pressure();
        test_overflow();
        test_ss_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
